mem_port_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction-fetch requester and the data (load/store) requester of the core.
- Sequences each access as request -> bus cycle -> response.
- Converts the data side's MemSize-style size flag (1 = 32-bit, 0 = 8-bit) into byte lanes, write-data replication and sign-extended byte reads.
- Sits between the fetch/LSU stages and the external memory bus.

---
 rtl/mem_port_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Fetch/data request ports and single-ported memory bus of the memory port arbiter.
// slave: arbiter side; master: core requesters plus memory slave.
interface mem_port_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic        d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        bus_cyc;
   logic        bus_stb;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_adr;
   logic [31:0] bus_dat_o;
   logic [31:0] bus_dat_i;
   logic        bus_ack;
   logic        bus_err_o;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, bus_dat_i, bus_ack,
      output if_rdata, if_ack, d_rdata, d_ack,
      output bus_cyc, bus_stb, bus_we, bus_sel, bus_adr, bus_dat_o, bus_err_o
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, bus_dat_i, bus_ack,
      input  if_rdata, if_ack, d_rdata, d_ack,
      input  bus_cyc, bus_stb, bus_we, bus_sel, bus_adr, bus_dat_o, bus_err_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data requesters (IDLE -> BUS -> RESP).
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned FAIR_LIMIT     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic       clk,
   input logic       reset,
   mem_port_if.slave mp
);

   if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_fair
      $error("mem_port_arbiter: FAIR_LIMIT must be in 1..15");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

   state_t      state_q;
   logic [3:0]  fair_q, fair_d;
   logic        req_data_q;
   logic [1:0]  lane_q;
   logic        size_q;
   logic        bus_cyc_q;
   logic        bus_we_q;
   logic [3:0]  bus_sel_q;
   logic [31:0] bus_adr_q;
   logic [31:0] bus_dat_q;
   logic        if_ack_q, d_ack_q;
   logic [31:0] if_rdata_q, d_rdata_q;

   logic        gnt_fetch, gnt_data;
   logic [31:0] adr_d, dat_d, load_d;
   logic [3:0]  sel_d;
   logic        we_d;
   logic [7:0]  ld_byte;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^mp.if_addr[1:0];

   // Data wins contention until it has taken FAIR_LIMIT grants in a row over a waiting fetch.
   always_comb begin
      gnt_fetch = 1'b0;
      gnt_data  = 1'b0;
      if (mp.if_req && mp.d_req) begin
         if (fair_q == FAIR_MAX) gnt_fetch = 1'b1;
         else                    gnt_data  = 1'b1;
      end else if (mp.if_req) begin
         gnt_fetch = 1'b1;
      end else if (mp.d_req) begin
         gnt_data = 1'b1;
      end

      fair_d = fair_q;
      if (!mp.if_req || gnt_fetch)            fair_d = 4'd0;
      else if (gnt_data && fair_q != FAIR_MAX) fair_d = fair_q + 4'd1;

      adr_d = {mp.if_addr[31:2], 2'b00};
      we_d  = 1'b0;
      sel_d = 4'b1111;
      dat_d = '0;
      if (gnt_data) begin
         adr_d = {mp.d_addr[31:2], 2'b00};
         we_d  = mp.d_we;
         sel_d = mp.d_size ? 4'b1111 : (4'b0001 << mp.d_addr[1:0]);
         dat_d = mp.d_size ? mp.d_wdata : {4{mp.d_wdata[7:0]}};
      end
   end

   always_comb begin
      ld_byte = mp.bus_dat_i[7:0];
      case (lane_q)
         2'd1:    ld_byte = mp.bus_dat_i[15:8];
         2'd2:    ld_byte = mp.bus_dat_i[23:16];
         2'd3:    ld_byte = mp.bus_dat_i[31:24];
         default: ld_byte = mp.bus_dat_i[7:0];
      endcase
      load_d = size_q ? mp.bus_dat_i : {{24{ld_byte[7]}}, ld_byte};
   end

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned   WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q;
   logic            err_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fair_q     <= '0;
         req_data_q <= 1'b0;
         lane_q     <= '0;
         size_q     <= 1'b0;
         bus_cyc_q  <= 1'b0;
         bus_we_q   <= 1'b0;
         bus_sel_q  <= '0;
         bus_adr_q  <= '0;
         bus_dat_q  <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
         wd_q       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               fair_q <= fair_d;
               if (gnt_fetch || gnt_data) begin
                  req_data_q <= gnt_data;
                  lane_q     <= mp.d_addr[1:0];
                  size_q     <= mp.d_size;
                  bus_adr_q  <= adr_d;
                  bus_we_q   <= we_d;
                  bus_sel_q  <= sel_d;
                  bus_dat_q  <= dat_d;
                  bus_cyc_q  <= 1'b1;
                  state_q    <= BUS;
`ifdef BUS_TIMEOUT_EN
                  wd_q       <= '0;
`endif
               end
            end
            BUS: begin
               if (mp.bus_ack) begin
                  bus_cyc_q <= 1'b0;
                  state_q   <= RESP;
                  if (req_data_q) begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= bus_we_q ? '0 : load_d;
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mp.bus_dat_i;
                  end
               end
`ifdef BUS_TIMEOUT_EN
               // A silent slave is abandoned; rdata stays 0 and the error rides on the ack.
               else if (wd_q == WD_LAST) begin
                  bus_cyc_q <= 1'b0;
                  state_q   <= RESP;
                  err_q     <= 1'b1;
                  if (req_data_q) d_ack_q  <= 1'b1;
                  else            if_ack_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
`endif
            end
            RESP: begin
               if_ack_q   <= 1'b0;
               d_ack_q    <= 1'b0;
               if_rdata_q <= '0;
               d_rdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
               err_q      <= 1'b0;
`endif
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mp.bus_cyc   = bus_cyc_q;
   assign mp.bus_stb   = bus_cyc_q;
   assign mp.bus_we    = bus_we_q;
   assign mp.bus_sel   = bus_sel_q;
   assign mp.bus_adr   = bus_adr_q;
   assign mp.bus_dat_o = bus_dat_q;
   assign mp.if_ack    = if_ack_q;
   assign mp.if_rdata  = if_rdata_q;
   assign mp.d_ack     = d_ack_q;
   assign mp.d_rdata   = d_rdata_q;
`ifdef BUS_TIMEOUT_EN
   assign mp.bus_err_o = err_q;
`else
   assign mp.bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan cases, then random traffic vs. a reference model.
module tb_mem_port_arbiter;
   localparam int FAIR_LIMIT     = 4;
   localparam int TIMEOUT_CYCLES = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_port_if mp ();

   mem_port_arbiter #(.FAIR_LIMIT(FAIR_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .mp    (mp)
   );

   int checks   = 0;
   int failures = 0;
   int fair_m   = 0;
   int last_win = 0;   // model winner: 0 none, 1 fetch, 2 data
   int dut_win  = 0;   // winner seen on the ack outputs

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One arbitration decision per IDLE cycle, from the fairness rules.
   function automatic int model_grant(input logic ir, input logic dr);
      int w;
      if (ir && dr)  w = (fair_m == FAIR_LIMIT) ? 1 : 2;
      else if (ir)   w = 1;
      else if (dr)   w = 2;
      else           w = 0;
      if (!ir || w == 1)                    fair_m = 0;
      else if (w == 2 && fair_m < FAIR_LIMIT) fair_m = fair_m + 1;
      return w;
   endfunction

   // Precondition: at a negedge with the DUT in IDLE. Returns at the next negedge in IDLE.
   task automatic access(input int delay, input logic [31:0] word);
      int          w;
      logic [31:0] ea, es, ed, er, b;
      logic        ewe;
      w        = model_grant(mp.if_req, mp.d_req);
      last_win = w;
      dut_win  = 0;
      if (w == 0) begin
         @(negedge clk);
         chk("idle_cyc", mp.bus_cyc, 0);
         return;
      end
      ed = '0;
      if (w == 1) begin
         ea  = mp.if_addr & 32'hFFFF_FFFC;
         es  = 32'hF;
         ewe = 1'b0;
         er  = word;
      end else begin
         ea  = mp.d_addr & 32'hFFFF_FFFC;
         es  = mp.d_size ? 32'hF : (32'd1 << mp.d_addr[1:0]);
         ewe = mp.d_we;
         ed  = mp.d_size ? mp.d_wdata : ({24'd0, mp.d_wdata[7:0]} * 32'h0101_0101);
         b   = (word >> (8 * mp.d_addr[1:0])) & 32'hFF;
         if (mp.d_we)       er = '0;
         else if (mp.d_size) er = word;
         else               er = b[7] ? (b | 32'hFFFF_FF00) : b;
      end
      @(negedge clk);
      chk("bus_cyc_stb", {mp.bus_cyc, mp.bus_stb}, 2'b11);
      chk("bus_adr", mp.bus_adr, ea);
      chk("bus_sel", mp.bus_sel, es);
      chk("bus_we", mp.bus_we, ewe);
      if (w == 2 && ewe) chk("bus_dat_o", mp.bus_dat_o, ed);
      repeat (delay) begin
         @(negedge clk);
         chk("bus_hold", {mp.bus_cyc, mp.bus_sel, mp.bus_adr[26:0]}, {1'b1, es[3:0], ea[26:0]});
      end
      mp.bus_ack   = 1'b1;
      mp.bus_dat_i = word;
      @(negedge clk);
      mp.bus_ack   = 1'b0;
      mp.bus_dat_i = $urandom;
      if (mp.if_ack && !mp.d_ack)      dut_win = 1;
      else if (mp.d_ack && !mp.if_ack) dut_win = 2;
      chk("ack_onehot", {mp.if_ack, mp.d_ack}, (w == 1) ? 2'b10 : 2'b01);
      chk("if_rdata", mp.if_rdata, (w == 1) ? er : 32'd0);
      chk("d_rdata", mp.d_rdata, (w == 2) ? er : 32'd0);
      chk("resp_cyc_err", {mp.bus_cyc, mp.bus_err_o}, 2'b00);
      @(negedge clk);
      chk("idle_acks", {mp.if_ack, mp.d_ack, mp.bus_cyc}, 3'b000);
      chk("idle_rdata", mp.if_rdata | mp.d_rdata, 0);
   endtask

   int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

   initial begin
      mp.if_req = 1'b0; mp.if_addr = '0;
      mp.d_req = 1'b0; mp.d_we = 1'b0; mp.d_size = 1'b0; mp.d_addr = '0; mp.d_wdata = '0;
      mp.bus_dat_i = '0; mp.bus_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bus", {mp.bus_cyc, mp.bus_stb, mp.bus_we, mp.bus_sel, mp.bus_err_o}, 0);
      chk("rst_adr_dat", mp.bus_adr | mp.bus_dat_o, 0);
      chk("rst_acks", {mp.if_ack, mp.d_ack}, 0);
      chk("rst_rdata", mp.if_rdata | mp.d_rdata, 0);
      reset = 1'b0;

      // fetch only
      mp.if_req = 1'b1; mp.if_addr = 32'h0000_1004;
      access(0, 32'hDEAD_BEEF);
      mp.if_req = 1'b0;

      // byte loads, negative then positive lane value
      mp.d_req = 1'b1; mp.d_we = 1'b0; mp.d_size = 1'b0; mp.d_addr = 32'h0000_2002;
      access(0, 32'h0080_0000);
      access(2, 32'h007F_0000);

      // byte store, then unaligned word store and word load
      mp.d_we = 1'b1; mp.d_addr = 32'h0000_2003; mp.d_wdata = 32'h1234_56AB;
      access(1, 32'h5555_AAAA);
      mp.d_size = 1'b1; mp.d_addr = 32'h0000_3007; mp.d_wdata = 32'hCAFE_F00D;
      access(0, 32'h0);
      mp.d_we = 1'b0;
      access(3, 32'h8765_4321);
      mp.d_req = 1'b0;
      access(0, 32'h0);

      // contention: both held high
      mp.if_req = 1'b1; mp.if_addr = 32'h0000_0100;
      mp.d_req = 1'b1; mp.d_we = 1'b0; mp.d_size = 1'b1; mp.d_addr = 32'h0000_0200;
      for (int i = 0; i < 10; i++) begin
         access(0, $urandom);
         chk("grant_order", dut_win, exp_order[i]);
      end
      mp.if_req = 1'b0; mp.d_req = 1'b0;
      access(0, 32'h0);

      // reset while the slave never acks
      mp.d_req = 1'b1; mp.d_addr = 32'h0000_0040;
      void'(model_grant(1'b0, 1'b1));
      @(negedge clk);
      chk("pre_rst_cyc", mp.bus_cyc, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1; mp.d_req = 1'b0;
      @(negedge clk);
      chk("rst_mid_cyc", mp.bus_cyc, 0);
      chk("rst_mid_acks", {mp.if_ack, mp.d_ack}, 0);
      reset = 1'b0; fair_m = 0;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_idle", {mp.bus_cyc, mp.if_ack, mp.d_ack}, 0);
      end
      mp.if_req = 1'b1; mp.if_addr = 32'h0000_0080;
      access(0, 32'h1357_9BDF);
      mp.if_req = 1'b0;

`ifdef BUS_TIMEOUT_EN
      begin
         int n;
         mp.d_req = 1'b1; mp.d_we = 1'b0; mp.d_size = 1'b1; mp.d_addr = 32'h0000_0100;
         mp.bus_dat_i = 32'hFFFF_FFFF;
         void'(model_grant(1'b0, 1'b1));
         @(negedge clk);
         n = 0;
         while (mp.bus_cyc && n < TIMEOUT_CYCLES + 4) begin
            @(negedge clk);
            n++;
         end
         chk("to_bus_cycles", n, TIMEOUT_CYCLES);
         chk("to_ack_err", {mp.d_ack, mp.bus_err_o, mp.bus_cyc}, 3'b110);
         chk("to_rdata", mp.d_rdata, 0);
         mp.d_req = 1'b0;
         @(negedge clk);
         chk("to_after", {mp.d_ack, mp.bus_err_o}, 0);

         // ack arriving on the limit cycle wins
         mp.d_req = 1'b1;
         void'(model_grant(1'b0, 1'b1));
         @(negedge clk);
         repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
         mp.bus_ack = 1'b1; mp.bus_dat_i = 32'h2468_ACE0;
         @(negedge clk);
         mp.bus_ack = 1'b0;
         chk("lim_ack_noerr", {mp.d_ack, mp.bus_err_o}, 2'b10);
         chk("lim_rdata", mp.d_rdata, 32'h2468_ACE0);
         mp.d_req = 1'b0;
         @(negedge clk);
      end
`endif

      // random traffic
      for (int it = 0; it < 80; it++) begin
         if (!mp.if_req && $urandom_range(0, 1) == 1) begin
            mp.if_req  = 1'b1;
            mp.if_addr = $urandom;
         end
         if (!mp.d_req && $urandom_range(0, 2) != 0) begin
            mp.d_req   = 1'b1;
            mp.d_we    = 1'($urandom_range(0, 1));
            mp.d_size  = 1'($urandom_range(0, 1));
            mp.d_addr  = $urandom;
            mp.d_wdata = $urandom;
         end
         access($urandom_range(0, 3), $urandom);
         if (last_win == 1)      mp.if_req = 1'b0;
         else if (last_win == 2) mp.d_req  = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
